alu_16b_arbiter: RTL and testbench
==================================

# alu_16b_arbiter

Sequencer and two-port round-robin arbiter in front of the registered 16-bit ALU (`ALU_16B`). It accepts operation requests from two independent requesters over valid/ready handshakes and issues them to the ALU one at a time. It captures `ALU_OUT` plus the five ALU flags after the ALU latency, and returns them on a shared, back-pressurable response channel tagged with the requester ID. Opcodes that must not reach the ALU are rejected locally with an error response.

## Interface
- `ALU_LATENCY`, 1: clock edges from ALU input sampling to valid `ALU_OUT`/flags; legal range 1..4.
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Req0_Valid`, `Req1_Valid`  in  1  request present.
- `Req0_A`, `Req1_A`  in  16  operand A.
- `Req0_B`, `Req1_B`  in  16  operand B.
- `Req0_FUN`, `Req1_FUN`  in  4  ALU opcode (0000 add … 1110 shift left).
- `Req0_Ready`, `Req1_Ready`  out  1  request accepted when Valid && Ready at an edge.
- `Rsp_Valid`  out  1  response present.
- `Rsp_Ready`  in  1  response consumed when Valid && Ready at an edge.
- `Rsp_Id`  out  1  requester index of response.
- `Rsp_Data`  out  16  captured `ALU_OUT`.
- `Rsp_Flags`  out  5  {Carry, Arith, Logic, CMP, Shift}, bits 4..0.
- `Rsp_Err`  out  1  request rejected, not issued.
- `ALU_A`, `ALU_B`  out  16  ALU operands.
- `ALU_FUN`  out  4  ALU opcode; 1111 = idle/NOP.
- `ALU_OUT`  in  16  ALU result.
- `Carry_Flag`, `Arith_flag`, `Logic_flag`, `CMP_flag`, `Shift_flag`  in  1 each  ALU flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant is computed combinationally from the valid requests and `Last_Grant`.
  - The granted requester's Ready = 1, the other's = 0. No valid request means both Ready = 0.
  - Arbitration: only one valid, that one wins. Both valid, the requester ≠ `Last_Grant` wins.
  - On accept: latch A, B, FUN and Id, and set `Last_Grant` = Id.
  - Reject rule: FUN = 1111, or FUN = 0011 with B = 0, goes to RESP with `Rsp_Data` = 0, `Rsp_Flags` = 0, `Rsp_Err` = 1.
  - Any other accepted request goes to ISSUE.
- **ISSUE** (1 cycle): drive `ALU_A`/`ALU_B`/`ALU_FUN` from the latched values. Then go to WAIT and load the wait counter with `ALU_LATENCY`.
- **WAIT:**
  - Hold the ALU inputs unchanged and decrement the counter each cycle.
  - In the cycle the counter = 1, capture `ALU_OUT` and the flags into the `Rsp_*` registers at the edge, with `Rsp_Err` = 0, `Rsp_Id` = latched Id. Go to RESP.
- **RESP:**
  - `Rsp_Valid` = 1; all `Rsp_*` outputs are stable until the handshake.
  - On `Rsp_Ready` = 1 at an edge, go to IDLE and clear `Rsp_Valid`.
  - Both Req Ready = 0 while in RESP.
- ALU inputs outside ISSUE/WAIT: `ALU_A` = 0, `ALU_B` = 0, `ALU_FUN` = 1111.
- Requests are never dropped. A requester holding Valid waits through other requests. Req data may change only after its handshake.
- **Reset** (any state, including mid-WAIT/RESP): the in-flight request is abandoned and no response is produced for it. Reset values:
  - state = IDLE
  - `Last_Grant` = 1, so Req0 wins the first tie
  - `Rsp_Valid` = 0, `Rsp_Id` = 0, `Rsp_Data` = 0, `Rsp_Flags` = 0, `Rsp_Err` = 0
  - `ALU_A`/`ALU_B` = 0, `ALU_FUN` = 1111
  - Req Ready outputs forced to 0 while `RST` = 1.

## Timing
- Accept at edge E0. ISSUE occupies the cycle after E0. WAIT occupies `ALU_LATENCY` cycles.
- `Rsp_Valid` rises after edge E0 + 2 + `ALU_LATENCY`. With the default latency that is 3 edges after accept.
- Rejected requests: `Rsp_Valid` rises one edge after accept.
- With `Rsp_Ready` held 1 and default latency, the sustained issue rate is one request per 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Req Ready is a combinational function of state, grant and `RST` only. There is no combinational path from `Rsp_Ready` or the ALU inputs to any output.

## Test plan
- **Single add:** Req0 A=1, B=1, FUN=0000 → `Rsp_Valid` 3 cycles after accept, `Rsp_Id` = 0, `Rsp_Data` = 0x0002, `Rsp_Flags` = 01000, `Rsp_Err` = 0.
- **Simultaneous requests after reset:** Req0 ADD 3+4 and Req1 SUB 9−2 → first response Id 0, Data 7. Second response Id 1, Data 7. `Req1_Ready` stays low until the first response completes.
- **Fairness:** both Valid held continuously for 6 requests → grants alternate 0,1,0,1,0,1. Each issue cycle shows the correct requester's operands on `ALU_A`/`ALU_B`.
- **Reject:** Req1 FUN=0011, A=8, B=0 → response one edge after accept with `Rsp_Err` = 1, Data = 0, Flags = 0. `ALU_FUN` stays 1111 throughout.
- **Backpressure:** `Rsp_Ready` = 0 for 5 cycles during RESP of Req0 AND 0x0F0F & 0x00FF → Data = 0x000F held stable, both Req Ready = 0. Release gives one handshake, then IDLE.
- **Reset mid-operation:** assert `RST` during WAIT of a multiply → next cycle: IDLE, `Rsp_Valid` = 0, `ALU_FUN` = 1111. No response for the aborted request. A new request afterwards completes normally.

Source files
------------

// File: rtl/alu_16b_arbiter.sv
// alu_16b_arbiter: two-port round-robin arbiter and sequencer in front of a
// registered 16-bit ALU. One request is in flight at a time; its result and
// flags come back on a shared response channel, tagged with the requester
// index. Opcode 1111 and divide-by-zero are answered locally with an error.
module alu_16b_arbiter #(
  parameter int ALU_LATENCY = 1  // legal range 1..4
) (
  input  logic        CLK,
  input  logic        RST,
  // requester 0
  input  logic        Req0_Valid,
  input  logic [15:0] Req0_A,
  input  logic [15:0] Req0_B,
  input  logic [3:0]  Req0_FUN,
  output logic        Req0_Ready,
  // requester 1
  input  logic        Req1_Valid,
  input  logic [15:0] Req1_A,
  input  logic [15:0] Req1_B,
  input  logic [3:0]  Req1_FUN,
  output logic        Req1_Ready,
  // shared response channel
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic        Rsp_Id,
  output logic [15:0] Rsp_Data,
  output logic [4:0]  Rsp_Flags,
  output logic        Rsp_Err,
  // ALU side
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] ALU_OUT,
  input  logic        Carry_Flag,
  input  logic        Arith_flag,
  input  logic        Logic_flag,
  input  logic        CMP_flag,
  input  logic        Shift_flag
);

  localparam logic [3:0] FUN_NOP  = 4'b1111;
  localparam logic [3:0] FUN_DIV  = 4'b0011;
  localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state;
  logic        last_grant;
  logic        lat_id;
  logic [2:0]  wait_cnt;

  logic        grant_id;
  logic        accept;
  logic        reject;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [3:0]  sel_fun;

  // Grant selection, request mux, ready generation and local reject decode.
  // NOTE: every signal gets a default at the top of always_comb so that no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_id   = 1'b0;
    sel_a      = Req0_A;
    sel_b      = Req0_B;
    sel_fun    = Req0_FUN;
    accept     = 1'b0;
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    reject     = 1'b0;

    // With both requesting, the one not served last time wins; otherwise the
    // only requester present wins.
    if (Req0_Valid && Req1_Valid) grant_id = ~last_grant;
    else                          grant_id = Req1_Valid;

    if (grant_id) begin
      sel_a   = Req1_A;
      sel_b   = Req1_B;
      sel_fun = Req1_FUN;
    end

    accept     = (state == S_IDLE) && (Req0_Valid || Req1_Valid) && !RST;
    Req0_Ready = accept && !grant_id;
    Req1_Ready = accept &&  grant_id;

    reject = (sel_fun == FUN_NOP) || ((sel_fun == FUN_DIV) && (sel_b == 16'd0));
  end

  // Sequencer FSM with registered ALU drive and response registers.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // Synchronous reset abandons any in-flight request without a response.
      state      <= S_IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      wait_cnt   <= 3'd0;
      Rsp_Valid  <= 1'b0;
      Rsp_Id     <= 1'b0;
      Rsp_Data   <= 16'd0;
      Rsp_Flags  <= 5'd0;
      Rsp_Err    <= 1'b0;
      ALU_A      <= 16'd0;
      ALU_B      <= 16'd0;
      ALU_FUN    <= FUN_NOP;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_id     <= grant_id;
            last_grant <= grant_id;
            if (reject) begin
              // Answered locally; the ALU never sees this request.
              Rsp_Valid <= 1'b1;
              Rsp_Id    <= grant_id;
              Rsp_Data  <= 16'd0;
              Rsp_Flags <= 5'd0;
              Rsp_Err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              // The ALU input registers double as the operand latch, so the
              // ALU sees the operands for the whole ISSUE cycle.
              ALU_A   <= sel_a;
              ALU_B   <= sel_b;
              ALU_FUN <= sel_fun;
              state   <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == 3'd1) begin
            Rsp_Valid <= 1'b1;
            Rsp_Id    <= lat_id;
            Rsp_Data  <= ALU_OUT;
            Rsp_Flags <= {Carry_Flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag};
            Rsp_Err   <= 1'b0;
            ALU_A     <= 16'd0;
            ALU_B     <= 16'd0;
            ALU_FUN   <= FUN_NOP;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        S_RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_16b_arbiter.sv
// Self-checking bench for alu_16b_arbiter. A behavioural registered ALU sits
// behind the DUT; a negedge monitor predicts grants, pushes expected
// responses into a scoreboard on every accept and pops them on handshake.
module tb_alu_16b_arbiter;

  localparam int LAT = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Req0_Valid, Req1_Valid;
  logic [15:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [3:0]  Req0_FUN, Req1_FUN;
  logic        Req0_Ready, Req1_Ready;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Id, Rsp_Err;
  logic [15:0] Rsp_Data;
  logic [4:0]  Rsp_Flags;
  logic [15:0] ALU_A, ALU_B, ALU_OUT;
  logic [3:0]  ALU_FUN;
  logic        Carry_Flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  alu_16b_arbiter #(.ALU_LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .Req0_Valid(Req0_Valid), .Req0_A(Req0_A), .Req0_B(Req0_B),
    .Req0_FUN(Req0_FUN), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_A(Req1_A), .Req1_B(Req1_B),
    .Req1_FUN(Req1_FUN), .Req1_Ready(Req1_Ready),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
    .Rsp_Data(Rsp_Data), .Rsp_Flags(Rsp_Flags), .Rsp_Err(Rsp_Err),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .Carry_Flag(Carry_Flag), .Arith_flag(Arith_flag), .Logic_flag(Logic_flag),
    .CMP_flag(CMP_flag), .Shift_flag(Shift_flag)
  );

  // Reference ALU: returns {carry, arith, logic, cmp, shift, result[15:0]}.
  function automatic logic [20:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] fun);
    logic [16:0] s;
    logic [15:0] r;
    logic c, ar, lo, cm, sh;
    s = 17'd0; r = 16'd0; c = 1'b0; ar = 1'b0; lo = 1'b0; cm = 1'b0; sh = 1'b0;
    case (fun)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; ar = 1'b1; end
      4'h1: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; ar = 1'b1; end
      4'h2: begin r = a * b; ar = 1'b1; end
      4'h3: begin r = (b != 16'd0) ? a / b : 16'd0; ar = 1'b1; end
      4'h4: begin r = a & b;    lo = 1'b1; end
      4'h5: begin r = a | b;    lo = 1'b1; end
      4'h6: begin r = ~(a & b); lo = 1'b1; end
      4'h7: begin r = ~(a | b); lo = 1'b1; end
      4'h8: begin r = a ^ b;    lo = 1'b1; end
      4'h9: begin r = ~(a ^ b); lo = 1'b1; end
      4'hA: begin r = {15'd0, a == b}; cm = 1'b1; end
      4'hB: begin r = {15'd0, a > b};  cm = 1'b1; end
      4'hC: begin r = {15'd0, a < b};  cm = 1'b1; end
      4'hD: begin r = a >> 1; sh = 1'b1; end
      4'hE: begin r = a << 1; sh = 1'b1; end
      default: ;
    endcase
    return {c, ar, lo, cm, sh, r};
  endfunction

  // Registered ALU behind the DUT (latency 1).
  logic [20:0] alu_q;
  always @(posedge CLK) alu_q <= alu_ref(ALU_A, ALU_B, ALU_FUN);
  assign ALU_OUT    = alu_q[15:0];
  assign Carry_Flag = alu_q[20];
  assign Arith_flag = alu_q[19];
  assign Logic_flag = alu_q[18];
  assign CMP_flag   = alu_q[17];
  assign Shift_flag = alu_q[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [4:0]  flags;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          cyc      = 0;
  logic        last_m   = 1'b1;
  logic        prev_v   = 1'b0;
  logic        iss_pend = 1'b0;
  logic        rej_pend = 1'b0;
  logic [15:0] iss_a, iss_b, m_a, m_b;
  logic [3:0]  iss_f, m_f;
  logic        pred, acc;
  logic [20:0] m_r;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      sb.delete();
      last_m   = 1'b1;
      prev_v   = 1'b0;
      iss_pend = 1'b0;
      rej_pend = 1'b0;
    end else begin
      if (iss_pend) begin
        check("issue_alu_a",   32'(ALU_A),   32'(iss_a));
        check("issue_alu_b",   32'(ALU_B),   32'(iss_b));
        check("issue_alu_fun", 32'(ALU_FUN), 32'(iss_f));
        iss_pend = 1'b0;
      end
      if (rej_pend) begin
        check("reject_alu_fun", 32'(ALU_FUN), 'hF);
        rej_pend = 1'b0;
      end
      check("ready_not_both", 32'(Req0_Ready & Req1_Ready), 0);
      if (Rsp_Valid) check("ready_in_resp", 32'({Req0_Ready, Req1_Ready}), 0);

      if ((Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready)) begin
        pred = (Req0_Valid && Req1_Valid) ? ~last_m : Req1_Valid;
        acc  = Req1_Valid && Req1_Ready;
        check("grant", 32'(acc), 32'(pred));
        last_m = acc;
        m_a = acc ? Req1_A   : Req0_A;
        m_b = acc ? Req1_B   : Req0_B;
        m_f = acc ? Req1_FUN : Req0_FUN;
        e_m.id      = acc;
        e_m.acc_cyc = cyc;
        if (m_f == 4'hF || (m_f == 4'h3 && m_b == 16'd0)) begin
          e_m.data  = 16'd0;
          e_m.flags = 5'd0;
          e_m.err   = 1'b1;
          rej_pend  = 1'b1;
        end else begin
          m_r       = alu_ref(m_a, m_b, m_f);
          e_m.data  = m_r[15:0];
          e_m.flags = m_r[20:16];
          e_m.err   = 1'b0;
          iss_pend  = 1'b1;
          iss_a = m_a; iss_b = m_b; iss_f = m_f;
        end
        sb.push_back(e_m);
      end

      if (Rsp_Valid && !prev_v) begin
        check("rsp_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0)
          check("rsp_latency", 32'(cyc - sb[0].acc_cyc), sb[0].err ? 1 : 2 + LAT);
      end

      if (Rsp_Valid && Rsp_Ready && sb.size() != 0) begin
        e_m = sb.pop_front();
        check("rsp_id",    32'(Rsp_Id),    32'(e_m.id));
        check("rsp_data",  32'(Rsp_Data),  32'(e_m.data));
        check("rsp_flags", 32'(Rsp_Flags), 32'(e_m.flags));
        check("rsp_err",   32'(Rsp_Err),   32'(e_m.err));
      end
      prev_v = Rsp_Valid;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] fun);
    bit done = 1'b0;
    if (id == 1'b0) begin
      Req0_A = a; Req0_B = b; Req0_FUN = fun; Req0_Valid = 1'b1;
    end else begin
      Req1_A = a; Req1_B = b; Req1_FUN = fun; Req1_Valid = 1'b1;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if ((id == 1'b0) ? Req0_Ready : Req1_Ready) done = 1'b1;
    end
    @(posedge CLK); #1;
    if (id == 1'b0) Req0_Valid = 1'b0;
    else            Req1_Valid = 1'b0;
    check("send_accepted", 32'(done), 1);
  endtask

  // Waits for Rsp_Valid and checks it against directed constants.
  task automatic expect_rsp(input string tag, input logic id, input logic [15:0] data,
                            input logic [4:0] flags, input logic err);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge CLK);
      if (Rsp_Valid) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 1);
    if (seen) begin
      check({tag, "_id"},    32'(Rsp_Id),    32'(id));
      check({tag, "_data"},  32'(Rsp_Data),  32'(data));
      check({tag, "_flags"}, 32'(Rsp_Flags), 32'(flags));
      check({tag, "_err"},   32'(Rsp_Err),   32'(err));
      @(posedge CLK); #1;
    end
  endtask

  task automatic drain();
    int i = 0;
    while ((sb.size() != 0 || Rsp_Valid) && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  task automatic reset_dut();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    RST = 1'b1; Rsp_Ready = 1'b1;
    Req0_Valid = 1'b0; Req0_A = '0; Req0_B = '0; Req0_FUN = '0;
    Req1_Valid = 1'b0; Req1_A = '0; Req1_B = '0; Req1_FUN = '0;

    // Reset state; Ready must stay low under reset even with requests present.
    repeat (2) @(posedge CLK);
    #1 Req0_Valid = 1'b1; Req1_Valid = 1'b1;
    @(negedge CLK);
    check("rst_req0_ready", 32'(Req0_Ready), 0);
    check("rst_req1_ready", 32'(Req1_Ready), 0);
    check("rst_rsp_valid",  32'(Rsp_Valid),  0);
    check("rst_rsp_id",     32'(Rsp_Id),     0);
    check("rst_rsp_data",   32'(Rsp_Data),   0);
    check("rst_rsp_flags",  32'(Rsp_Flags),  0);
    check("rst_rsp_err",    32'(Rsp_Err),    0);
    check("rst_alu_a",      32'(ALU_A),      0);
    check("rst_alu_b",      32'(ALU_B),      0);
    check("rst_alu_fun",    32'(ALU_FUN),    'hF);
    @(posedge CLK); #1 Req0_Valid = 1'b0; Req1_Valid = 1'b0; RST = 1'b0;

    // Single add.
    send(1'b0, 16'd1, 16'd1, 4'h0);
    expect_rsp("add", 1'b0, 16'h0002, 5'b01000, 1'b0);
    drain();

    // Simultaneous requests straight after reset: Req0 wins the first tie.
    reset_dut();
    fork
      begin
        fork
          send(1'b0, 16'd3, 16'd4, 4'h0);
          send(1'b1, 16'd9, 16'd2, 4'h1);
        join
      end
      begin
        expect_rsp("sim_first",  1'b0, 16'd7, 5'b01000, 1'b0);
        expect_rsp("sim_second", 1'b1, 16'd7, 5'b01000, 1'b0);
      end
    join
    drain();

    // Fairness: both requesters keep Valid high for three requests each.
    fork
      begin
        send(1'b0, 16'd10,    16'd1,    4'h0);
        send(1'b0, 16'hA5A5,  16'h0FF0, 4'h8);
        send(1'b0, 16'h8001,  16'd0,    4'hE);
      end
      begin
        send(1'b1, 16'd100,   16'd1,    4'h1);
        send(1'b1, 16'h1200,  16'h0034, 4'h5);
        send(1'b1, 16'd5,     16'd9,    4'hB);
      end
    join
    drain();

    // Rejects: divide by zero and the NOP opcode.
    send(1'b1, 16'd8, 16'd0, 4'h3);
    expect_rsp("rej_div0", 1'b1, 16'd0, 5'd0, 1'b1);
    send(1'b0, 16'd8, 16'd2, 4'hF);
    expect_rsp("rej_nop", 1'b0, 16'd0, 5'd0, 1'b1);
    check("rej_alu_fun_after", 32'(ALU_FUN), 'hF);
    send(1'b0, 16'd8, 16'd2, 4'h3);
    expect_rsp("div_ok", 1'b0, 16'd4, 5'b01000, 1'b0);
    drain();

    // Backpressure with Req1 waiting behind the stalled response.
    @(posedge CLK); #1 Rsp_Ready = 1'b0;
    fork
      send(1'b0, 16'h0F0F, 16'h00FF, 4'h4);
      begin
        expect_rsp("bp", 1'b0, 16'h000F, 5'b00100, 1'b0);
        fork
          send(1'b1, 16'd5, 16'd3, 4'h5);
          begin
            repeat (5) begin
              @(negedge CLK);
              check("bp_valid", 32'(Rsp_Valid),  1);
              check("bp_data",  32'(Rsp_Data),   'h000F);
              check("bp_r0",    32'(Req0_Ready), 0);
              check("bp_r1",    32'(Req1_Ready), 0);
            end
            @(posedge CLK); #1 Rsp_Ready = 1'b1;
            @(negedge CLK);
            @(negedge CLK);
            check("bp_release_valid", 32'(Rsp_Valid), 0);
          end
        join
      end
    join
    drain();

    // Reset in the middle of a multiply: no response for it, then recover.
    send(1'b0, 16'd300, 16'd200, 4'h2);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_valid",   32'(Rsp_Valid), 0);
    check("mid_rst_alu_fun", 32'(ALU_FUN),   'hF);
    check("mid_rst_alu_a",   32'(ALU_A),     0);
    repeat (4) begin
      @(negedge CLK);
      check("mid_rst_no_rsp", 32'(Rsp_Valid), 0);
    end
    send(1'b1, 16'd7, 16'd6, 4'h2);
    expect_rsp("after_rst", 1'b1, 16'd42, 5'b01000, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
